// File: rtl/muldiv_unit_pkg.sv
// Shared op-code constants and FSM state encoding for the multiply/divide unit.
package muldiv_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/flop_en_r.sv
// Resettable enable flop: async active-high reset to zero, loads d when enabled.
module flop_en_r #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  // Multiply keeps the multiplier in the low half; divide keeps remainder:quotient.
  always_comb begin
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, opnd_i};
    acc_o  = {sum, acc_i[WIDTH-1:1]};
    if (is_div_i) begin
      if (!diff[WIDTH]) acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      else              acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH;

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] araw_q, araw_d;
  logic             negq_q, negq_d, negr_q, negr_d, div0_q, div0_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             hi_en, lo_en;
  logic [WIDTH-1:0] hi_d, lo_d;

  logic             in_signed, in_div, q_is_div;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [AW-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign in_signed = (op == MD_MULT) || (op == MD_DIV);
  assign in_div    = (op == MD_DIV) || (op == MD_DIVU);
  assign abs_a     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b     = (in_signed && b[WIDTH-1]) ? -b : b;
  assign q_is_div  = (op_q == MD_DIV) || (op_q == MD_DIVU);

  assign prod_fix = negq_q ? -acc_q : acc_q;
  assign quo_fix  = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = negr_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (q_is_div),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step)
  );

  // Next-state, datapath loads and HI/LO write enables.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    div0_d  = div0_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_en   = 1'b0;
    lo_en   = 1'b0;
    hi_d    = hi;
    lo_d    = lo;
    unique case (state_q)
      MD_IDLE: begin
        if (start && !cancel) begin
          case (op)
            MD_MTHI: begin
              hi_en = 1'b1;
              hi_d  = a;
            end
            MD_MTLO: begin
              lo_en = 1'b1;
              lo_d  = a;
            end
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              state_d = MD_RUN;
              busy_d  = 1'b1;
              cnt_d   = CW'(WIDTH);
              op_d    = op;
              araw_d  = a;
              div0_d  = (b == '0);
              negq_d  = in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              negr_d  = (op == MD_DIV) && a[WIDTH-1];
              if (in_div) begin
                acc_d  = {{WIDTH{1'b0}}, abs_a};
                opnd_d = abs_b;
              end else begin
                acc_d  = {{WIDTH{1'b0}}, abs_b};
                opnd_d = abs_a;
              end
            end
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        if (cancel) begin
          state_d = MD_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
        if (!cancel) begin
          hi_en  = 1'b1;
          lo_en  = 1'b1;
          done_d = 1'b1;
          if (q_is_div) begin
            // Divide by zero reports the raw dividend and an all-ones quotient.
            hi_d = div0_q ? araw_q : rem_fix;
            lo_d = div0_q ? '1 : quo_fix;
          end else begin
            hi_d = prod_fix[AW-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: begin
        state_d = MD_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      acc_q   <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      div0_q  <= div0_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  flop_en_r #(.WIDTH(WIDTH)) u_hi (
    .clk   (clk),
    .reset (reset),
    .en_i  (hi_en),
    .d_i   (hi_d),
    .q_o   (hi)
  );

  flop_en_r #(.WIDTH(WIDTH)) u_lo (
    .clk   (clk),
    .reset (reset),
    .en_i  (lo_en),
    .d_i   (lo_d),
    .q_o   (lo)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total;
  int          bad;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Architectural result from plain 64-bit integer arithmetic.
  task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint      sa, sb, q, rm;
    logic [63:0] r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      3'd1: begin r = sa * sb; exp_hi = r[63:32]; exp_lo = r[31:0]; end
      3'd2: begin r = {32'h0, ma} * {32'h0, mb}; exp_hi = r[63:32]; exp_lo = r[31:0]; end
      3'd3: begin
        if (mb == 32'h0) begin
          exp_hi = ma; exp_lo = 32'hFFFF_FFFF;
        end else begin
          q = sa / sb; rm = sa % sb;
          r = q;  exp_lo = r[31:0];
          r = rm; exp_hi = r[31:0];
        end
      end
      3'd4: begin
        if (mb == 32'h0) begin
          exp_hi = ma; exp_lo = 32'hFFFF_FFFF;
        end else begin
          exp_lo = ma / mb; exp_hi = ma % mb;
        end
      end
      3'd5: exp_hi = ma;
      3'd6: exp_lo = ma;
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic move_to(input string tag, input logic [2:0] mop, input logic [31:0] ma);
    model(mop, ma, 32'h0);
    op = mop; a = ma; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    check({tag, ".busy"}, 64'(busy), 64'd0);
  endtask

  // Issue a mul/div, scramble a/b while it runs, optionally poke start mid-run.
  task automatic run_op(input string tag, input logic [2:0] mop, input logic [31:0] ma,
                        input logic [31:0] mb, input int inject);
    int cyc;
    int bcnt;
    model(mop, ma, mb);
    op = mop; a = ma; b = mb; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) bcnt++;
      a = $urandom;
      b = $urandom;
      if (cyc == inject) begin
        start = 1'b1;
        op = 3'($urandom_range(1, 6));
      end else begin
        start = 1'b0;
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".latency"}, 64'(cyc), 64'd34);
    check({tag, ".busy_cycles"}, 64'(bcnt), 64'd33);
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    step();
    check({tag, ".done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int dcnt;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    clk = 1'b0; reset = 1'b1; start = 1'b0; cancel = 1'b0;
    op = 3'd0; a = 32'h0; b = 32'h0;
    total = 0; bad = 0; exp_hi = 32'h0; exp_lo = 32'h0;

    #12;
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    reset = 1'b0;
    step();

    run_op("mult_neg1x2", 3'd1, 32'hFFFF_FFFF, 32'h0000_0002, -1);
    run_op("multu_ffx2", 3'd2, 32'hFFFF_FFFF, 32'h0000_0002, -1);
    run_op("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'h0000_0002, -1);
    run_op("divu_100_7", 3'd4, 32'd100, 32'd7, -1);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op("divu_by0", 3'd4, 32'h1234_5678, 32'h0, -1);
    run_op("div_by0_neg", 3'd3, 32'hF000_0001, 32'h0, -1);
    run_op("div_7_m2", 3'd3, 32'd7, 32'hFFFF_FFFE, -1);

    move_to("mthi", 3'd5, 32'hDEAD_BEEF);
    move_to("mtlo", 3'd6, 32'h00C0_FFEE);

    // Cancel in flight: HI/LO keep the preloaded pattern, no done pulse.
    move_to("pre_hi", 3'd5, 32'hAAAA_AAAA);
    move_to("pre_lo", 3'd6, 32'hAAAA_AAAA);
    op = 3'd1; a = 32'd3; b = 32'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    check("cancel.busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel.busy", 64'(busy), 64'd0);
    check("cancel.hi", 64'(hi), 64'hAAAA_AAAA);
    check("cancel.lo", 64'(lo), 64'hAAAA_AAAA);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) dcnt++;
      step();
    end
    check("cancel.no_done", 64'(dcnt), 64'd0);
    run_op("multu_after_cancel", 3'd2, 32'd3, 32'd5, -1);

    // Cancel together with start in IDLE latches nothing.
    op = 3'd5; a = 32'h1111_2222; start = 1'b1; cancel = 1'b1;
    step();
    check("cancel_start.hi", 64'(hi), 64'(exp_hi));
    op = 3'd3; a = 32'd9; b = 32'd2;
    step();
    start = 1'b0; cancel = 1'b0;
    check("cancel_start.busy", 64'(busy), 64'd0);
    step();
    check("cancel_start.busy2", 64'(busy), 64'd0);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    check("cancel_idle.lo", 64'(lo), 64'(exp_lo));

    // Asynchronous reset in the middle of a divide.
    op = 3'd3; a = 32'hFFFF_0000; b = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (19) step();
    check("rst_mid.busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("rst_mid.hi", 64'(hi), 64'd0);
    check("rst_mid.lo", 64'(lo), 64'd0);
    check("rst_mid.busy", 64'(busy), 64'd0);
    #2;
    reset = 1'b0;
    exp_hi = 32'h0; exp_lo = 32'h0;
    step();
    check("rst_mid.busy_after", 64'(busy), 64'd0);
    check("rst_mid.done_after", 64'(done), 64'd0);

    run_op("divu_inject", 3'd4, 32'd100, 32'd7, 5);
    run_op("mult_inject", 3'd1, 32'hFFFF_FFF3, 32'd1234, 20);

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(1, 6));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
        3: rb = 32'($urandom_range(0, 15)) | 32'hFFFF_FFF0;
        default: ;
      endcase
      if (rop == 3'd5 || rop == 3'd6) move_to("rand_mt", rop, ra);
      else run_op("rand_op", rop, ra, rb, (n % 3 == 0) ? 7 : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
